// File: rtl/bit_read_sequencer_if.sv
// Request/response and shifter-command bundle for the CAVLC bit-read sequencer.
// The slave side is the sequencer; the master side is the parser/shifter harness.
interface bit_read_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             Enable;
  logic             ReqValid;
  logic             ReqReady;
  logic [1:0]       ReqType;
  logic [4:0]       ReqLen;
  logic             ShifterReady;
  logic [15:0]      Window;
  logic             ShiftEn;
  logic [4:0]       NumShift;
  logic             RspValid;
  logic [15:0]      RspData;
  logic             RspErr;
  logic             Busy;
  logic [CNT_W-1:0] BitsConsumed;

  modport slave (
    input  Enable, ReqValid, ReqType, ReqLen, ShifterReady, Window,
    output ReqReady, ShiftEn, NumShift, RspValid, RspData, RspErr, Busy, BitsConsumed
  );

  modport master (
    output Enable, ReqValid, ReqType, ReqLen, ShifterReady, Window,
    input  ReqReady, ShiftEn, NumShift, RspValid, RspData, RspErr, Busy, BitsConsumed
  );
endinterface

// File: rtl/bit_read_sequencer.sv
// Bit-read sequencer: turns one u(n)/ue(v)/se(v)/skip(n) request into barrel
// shifter commands and returns the decoded value on a one-cycle strobe.
module bit_read_sequencer #(
  parameter int CNT_W  = 32,
  parameter int MAX_LZ = 15
) (
  input logic                 Clk,
  input logic                 Reset,
  bit_read_sequencer_if.slave bus
);

  localparam logic [1:0] TY_U    = 2'b00;
  localparam logic [1:0] TY_UE   = 2'b01;
  localparam logic [1:0] TY_SE   = 2'b10;
  localparam logic [1:0] TY_SKIP = 2'b11;
  localparam logic [4:0] MaxLz   = 5'(MAX_LZ);

  typedef enum logic [1:0] {IDLE, FIXED, PREFIX, SUFFIX} state_t;

  state_t           state, stateNext;
  logic [1:0]       typeQ;
  logic [4:0]       lenQ;
  logic [4:0]       lzQ, lzNext;
  logic             rspValidQ, rspErrQ;
  logic [15:0]      rspDataQ;
  logic [CNT_W-1:0] bitsQ;

  logic             accept;
  logic             shiftEn;
  logic [4:0]       numShift;
  logic             rspSet, rspErrSet;
  logic [15:0]      rspDataNext;
  logic [4:0]       lz;
  logic [15:0]      fixVal, sufVal;
  logic [16:0]      codeNum;

  // Leading-zero count of a 16-bit window; 16 when the window is all zeros.
  function automatic logic [4:0] lzc(input logic [15:0] w);
    logic [4:0] r;
    r = 5'd16;
    for (int i = 0; i < 16; i++)
      if (w[i]) r = 5'(15 - i);
    return r;
  endfunction

  // Exp-Golomb codeNum to output value: ue passes through, se maps
  // odd k -> +(k+1)/2 and even k -> -(k/2).
  function automatic logic [15:0] mapCode(input logic [16:0] k, input logic isSe);
    logic [16:0] h;
    if (!isSe) begin
      h = k;
    end else if (k[0]) begin
      h = (k + 17'd1) >> 1;
    end else begin
      h = ~(k >> 1) + 17'd1;
    end
    return h[15:0];
  endfunction

  // A request is never taken in the cycle a response is on the bus, so
  // parsers see the result before issuing the next read.
  assign bus.ReqReady = !Reset & bus.Enable & bus.ShifterReady &
                        (state == IDLE) & !rspValidQ;
  assign accept       = bus.ReqValid & bus.ReqReady;

  assign lz      = lzc(bus.Window);
  assign fixVal  = bus.Window >> (5'd16 - lenQ);
  assign sufVal  = bus.Window >> (5'd16 - lzQ);
  assign codeNum = (17'd1 << lzQ) - 17'd1 + {1'b0, sufVal};

  // Next state, shifter command and response setup from state and Window.
  always_comb begin
    stateNext   = state;
    lzNext      = lzQ;
    shiftEn     = 1'b0;
    numShift    = 5'd0;
    rspSet      = 1'b0;
    rspErrSet   = 1'b0;
    rspDataNext = 16'd0;
    case (state)
      IDLE: begin
        if (accept)
          stateNext = (bus.ReqType == TY_U || bus.ReqType == TY_SKIP) ? FIXED : PREFIX;
      end
      FIXED: begin
        if (bus.ShifterReady) begin
          stateNext = IDLE;
          rspSet    = 1'b1;
          if (lenQ > 5'd16) begin
            rspErrSet = 1'b1;
          end else begin
            shiftEn  = (lenQ != 5'd0);
            numShift = lenQ;
            if (typeQ == TY_U && lenQ != 5'd0) rspDataNext = fixVal;
          end
        end
      end
      PREFIX: begin
        if (bus.ShifterReady) begin
          if (bus.Window == 16'd0 || lz > MaxLz) begin
            stateNext = IDLE;
            rspSet    = 1'b1;
            rspErrSet = 1'b1;
          end else begin
            shiftEn  = 1'b1;
            numShift = lz + 5'd1;
            if (lz == 5'd0) begin
              // Single '1' bit: codeNum 0 maps to 0 for both ue and se.
              stateNext = IDLE;
              rspSet    = 1'b1;
            end else begin
              lzNext    = lz;
              stateNext = SUFFIX;
            end
          end
        end
      end
      SUFFIX: begin
        if (bus.ShifterReady) begin
          shiftEn     = 1'b1;
          numShift    = lzQ;
          rspSet      = 1'b1;
          rspDataNext = mapCode(codeNum, typeQ == TY_SE);
          stateNext   = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Disabled block issues nothing and drops any in-flight request.
    if (!bus.Enable) begin
      shiftEn   = 1'b0;
      numShift  = 5'd0;
      rspSet    = 1'b0;
      rspErrSet = 1'b0;
      stateNext = IDLE;
    end
  end

  // State register and request latch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      typeQ <= TY_U;
      lenQ  <= 5'd0;
      lzQ   <= 5'd0;
    end else if (!bus.Enable) begin
      state <= IDLE;
      typeQ <= TY_U;
      lenQ  <= 5'd0;
      lzQ   <= 5'd0;
    end else begin
      state <= stateNext;
      lzQ   <= lzNext;
      if (accept) begin
        typeQ <= bus.ReqType;
        lenQ  <= bus.ReqLen;
      end
    end
  end

  // Registered response strobe; data holds between strobes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rspValidQ <= 1'b0;
      rspErrQ   <= 1'b0;
      rspDataQ  <= 16'd0;
    end else if (!bus.Enable) begin
      rspValidQ <= 1'b0;
      rspErrQ   <= 1'b0;
      rspDataQ  <= 16'd0;
    end else begin
      rspValidQ <= rspSet;
      rspErrQ   <= rspSet & rspErrSet;
      if (rspSet) rspDataQ <= rspDataNext;
    end
  end

  // Running count of consumed bits, wraps naturally at 2^CNT_W.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bitsQ <= '0;
    end else if (!bus.Enable) begin
      bitsQ <= '0;
    end else if (shiftEn) begin
      bitsQ <= bitsQ + CNT_W'(numShift);
    end
  end

  assign bus.ShiftEn      = shiftEn;
  assign bus.NumShift     = numShift;
  assign bus.RspValid     = rspValidQ;
  assign bus.RspErr       = rspErrQ;
  assign bus.RspData      = rspDataQ;
  assign bus.Busy         = (state != IDLE);
  assign bus.BitsConsumed = bitsQ;

endmodule

// File: tb/tb_bit_read_sequencer.sv
// Directed bench for bit_read_sequencer with a small bitstream/shifter model.
module tb_bit_read_sequencer;

  logic Clk = 1'b0;
  logic Reset;
  int   nChecks = 0;
  int   nFail   = 0;

  bit_read_sequencer_if #(.CNT_W(32)) bus ();

  bit_read_sequencer #(.CNT_W(32), .MAX_LZ(15)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Shifter model: a 128-bit stream; Window is the next 16 unconsumed bits.
  logic [127:0] bits = '0;
  int           shiftTotal = 0;
  int           base = 0;
  logic [15:0]  win;

  always @(posedge Clk)
    if (bus.ShiftEn) shiftTotal <= shiftTotal + int'(bus.NumShift);

  always_comb begin
    int off;
    off = shiftTotal - base;
    if (off < 0 || off > 112) off = 0;
    win = bits[127 - off -: 16];
  end
  assign bus.Window = win;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [127:0] v);
    bits = v;
    base = shiftTotal;
  endtask

  // Hold ReqValid across one edge; returns in cycle t+1.
  task automatic issue(input logic [1:0] ty, input logic [4:0] len);
    bus.ReqValid = 1'b1;
    bus.ReqType  = ty;
    bus.ReqLen   = len;
    tick();
    bus.ReqValid = 1'b0;
  endtask

  initial begin
    Reset            = 1'b1;
    bus.Enable       = 1'b1;
    bus.ShifterReady = 1'b0;
    bus.ReqValid     = 1'b0;
    bus.ReqType      = 2'b00;
    bus.ReqLen       = 5'd0;
    tick(); tick();

    // reset state
    chk("rst_reqready", 32'(bus.ReqReady), 32'd0);
    chk("rst_shiften",  32'(bus.ShiftEn),  32'd0);
    chk("rst_numshift", 32'(bus.NumShift), 32'd0);
    chk("rst_rspvalid", 32'(bus.RspValid), 32'd0);
    chk("rst_rspdata",  32'(bus.RspData),  32'd0);
    chk("rst_busy",     32'(bus.Busy),     32'd0);
    chk("rst_bits",     bus.BitsConsumed,  32'd0);

    Reset = 1'b0;
    bus.ShifterReady = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.ReqReady), 32'd1);

    // u(5) on 0xA5C3 -> 10100b = 0x14
    load({16'hA5C3, 112'd0});
    issue(2'b00, 5'd5);
    chk("u5_shiften",  32'(bus.ShiftEn),  32'd1);
    chk("u5_numshift", 32'(bus.NumShift), 32'd5);
    chk("u5_busy",     32'(bus.Busy),     32'd1);
    tick();
    chk("u5_rspvalid", 32'(bus.RspValid), 32'd1);
    chk("u5_rspdata",  32'(bus.RspData),  32'h0014);
    chk("u5_rsperr",   32'(bus.RspErr),   32'd0);
    chk("u5_bits",     bus.BitsConsumed,  32'd5);
    chk("u5_noready",  32'(bus.ReqReady), 32'd0);
    tick();
    chk("u5_strobe1",  32'(bus.RspValid), 32'd0);
    chk("u5_hold",     32'(bus.RspData),  32'h0014);

    // ue on 00101... -> L=2, suffix 01, codeNum 4
    load({16'b0010_1000_0000_0000, 112'd0});
    issue(2'b01, 5'd0);
    chk("ue_pre_en",   32'(bus.ShiftEn),  32'd1);
    chk("ue_pre_n",    32'(bus.NumShift), 32'd3);
    tick();
    chk("ue_suf_en",   32'(bus.ShiftEn),  32'd1);
    chk("ue_suf_n",    32'(bus.NumShift), 32'd2);
    chk("ue_suf_norsp",32'(bus.RspValid), 32'd0);
    tick();
    chk("ue_rspvalid", 32'(bus.RspValid), 32'd1);
    chk("ue_rspdata",  32'(bus.RspData),  32'h0004);
    chk("ue_rsperr",   32'(bus.RspErr),   32'd0);
    chk("ue_bits",     bus.BitsConsumed,  32'd10);
    tick();

    // se on same stream -> k=4 -> -2
    load({16'b0010_1000_0000_0000, 112'd0});
    issue(2'b10, 5'd0);
    tick(); tick();
    chk("se_rspvalid", 32'(bus.RspValid), 32'd1);
    chk("se_rspdata",  32'(bus.RspData),  32'hFFFE);
    chk("se_bits",     bus.BitsConsumed,  32'd15);
    tick();

    // ue on 1011... -> single-bit code, value 0 at t+2
    load({16'hB000, 112'd0});
    issue(2'b01, 5'd0);
    chk("ue1_en",      32'(bus.ShiftEn),  32'd1);
    chk("ue1_n",       32'(bus.NumShift), 32'd1);
    tick();
    chk("ue1_rspvalid",32'(bus.RspValid), 32'd1);
    chk("ue1_rspdata", 32'(bus.RspData),  32'h0000);
    chk("ue1_busy",    32'(bus.Busy),     32'd0);
    chk("ue1_bits",    bus.BitsConsumed,  32'd16);
    tick();

    // ue on all-zero window -> error, no shift
    load(128'd0);
    issue(2'b01, 5'd0);
    chk("uez_noshift", 32'(bus.ShiftEn),  32'd0);
    tick();
    chk("uez_rspvalid",32'(bus.RspValid), 32'd1);
    chk("uez_rsperr",  32'(bus.RspErr),   32'd1);
    chk("uez_rspdata", 32'(bus.RspData),  32'h0000);
    chk("uez_busy",    32'(bus.Busy),     32'd0);
    chk("uez_bits",    bus.BitsConsumed,  32'd16);
    tick();
    chk("uez_errclr",  32'(bus.RspErr),   32'd0);

    // u(20) -> error, no shift
    load({16'hFFFF, 112'd0});
    issue(2'b00, 5'd20);
    chk("u20_noshift", 32'(bus.ShiftEn),  32'd0);
    tick();
    chk("u20_rspvalid",32'(bus.RspValid), 32'd1);
    chk("u20_rsperr",  32'(bus.RspErr),   32'd1);
    chk("u20_rspdata", 32'(bus.RspData),  32'h0000);
    chk("u20_busy",    32'(bus.Busy),     32'd0);
    tick();

    // ue 0001 101... (L=3, suffix 101, codeNum 12) with a 3-cycle stall in PREFIX
    load({16'b0001_1010_0000_0000, 112'd0});
    issue(2'b01, 5'd0);
    bus.ShifterReady = 1'b0;
    #1;
    chk("stall_en0",   32'(bus.ShiftEn),  32'd0);
    tick();
    chk("stall_en1",   32'(bus.ShiftEn),  32'd0);
    chk("stall_busy",  32'(bus.Busy),     32'd1);
    tick();
    chk("stall_en2",   32'(bus.ShiftEn),  32'd0);
    chk("stall_norsp", 32'(bus.RspValid), 32'd0);
    tick();
    bus.ShifterReady = 1'b1;
    #1;
    chk("stall_pre_n", 32'(bus.NumShift), 32'd4);
    chk("stall_pre_en",32'(bus.ShiftEn),  32'd1);
    tick();
    chk("stall_suf_n", 32'(bus.NumShift), 32'd3);
    chk("stall_suf_rv",32'(bus.RspValid), 32'd0);
    tick();
    chk("stall_rspvalid", 32'(bus.RspValid), 32'd1);
    chk("stall_rspdata",  32'(bus.RspData),  32'h000C);
    chk("stall_bits",     bus.BitsConsumed,  32'd23);
    tick();

    // asynchronous reset in the middle of SUFFIX
    load({16'b0010_1000_0000_0000, 112'd0});
    issue(2'b01, 5'd0);
    tick();
    chk("mid_suf_en",  32'(bus.ShiftEn),  32'd1);
    Reset = 1'b1;
    #1;
    chk("arst_shiften", 32'(bus.ShiftEn),  32'd0);
    chk("arst_busy",    32'(bus.Busy),     32'd0);
    chk("arst_rspvalid",32'(bus.RspValid), 32'd0);
    chk("arst_bits",    bus.BitsConsumed,  32'd0);
    tick();
    chk("arst_norsp",   32'(bus.RspValid), 32'd0);
    Reset = 1'b0;
    tick();
    chk("arst_ready",   32'(bus.ReqReady), 32'd1);

    // back-to-back skip(16) then u(16) with ReqValid held
    load({16'h1234, 16'hBEEF, 96'd0});
    bus.ReqValid = 1'b1;
    bus.ReqType  = 2'b11;
    bus.ReqLen   = 5'd16;
    tick();
    bus.ReqType  = 2'b00;
    chk("b2b_skip_n",   32'(bus.NumShift), 32'd16);
    chk("b2b_skip_en",  32'(bus.ShiftEn),  32'd1);
    chk("b2b_notready1",32'(bus.ReqReady), 32'd0);
    tick();
    chk("b2b_skip_rv",  32'(bus.RspValid), 32'd1);
    chk("b2b_skip_data",32'(bus.RspData),  32'h0000);
    chk("b2b_notready2",32'(bus.ReqReady), 32'd0);
    tick();
    chk("b2b_ready_t3", 32'(bus.ReqReady), 32'd1);
    tick();
    bus.ReqValid = 1'b0;
    chk("b2b_u_en",     32'(bus.ShiftEn),  32'd1);
    chk("b2b_u_n",      32'(bus.NumShift), 32'd16);
    tick();
    chk("b2b_u_rv",     32'(bus.RspValid), 32'd1);
    chk("b2b_u_data",   32'(bus.RspData),  32'hBEEF);
    chk("b2b_bits",     bus.BitsConsumed,  32'd32);
    tick();

    // Enable low aborts an in-flight u(8) without a response
    load({16'h5A5A, 112'd0});
    issue(2'b00, 5'd8);
    bus.Enable = 1'b0;
    tick();
    chk("en_busy",      32'(bus.Busy),     32'd0);
    chk("en_rspvalid",  32'(bus.RspValid), 32'd0);
    chk("en_bits",      bus.BitsConsumed,  32'd0);
    chk("en_rspdata",   32'(bus.RspData),  32'd0);
    bus.Enable = 1'b1;
    tick();
    chk("en_norsp",     32'(bus.RspValid), 32'd0);
    chk("en_ready",     32'(bus.ReqReady), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
